// File: rtl/uart1_pkg.sv
// ============================================================================
// uart1_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared types and constants for the uart1 transmitter slice.
//           Holds the frame-state enum and the frame geometry constants used
//           by uart1_tx and its bit-period timer.
// Ports   : none (package)
// Config  : UART1_TX_PARITY_EN - when defined, frames carry an even-parity
//           bit between the last data bit and the stop bit (11-bit frame).
// ============================================================================
package uart1_pkg;

    // Frame sequencer states. PARITY is only ever entered when the parity
    // option is compiled in; the encoding is kept identical in both builds.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS = 8;

`ifdef UART1_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage : uart1_pkg

// File: rtl/uart1_tx_baud_tick.sv
// ============================================================================
// uart_baud_tick
// ----------------------------------------------------------------------------
// Purpose : Bit-period timer for the uart1 transmitter. Counts clock cycles
//           0..CLOCK_DIV-1 while 'run' is high and flags the last cycle of
//           each bit period with a one-cycle 'tick'. The counter wraps to 0
//           on the tick and is held at 0 while 'run' is low, so the first
//           bit period after 'run' rises is always a full CLOCK_DIV cycles.
//
// Parameters:
//   CLOCK_DIV          - clk cycles per bit, must be >= 2
//   CLOCK_COUNTER_BITS - counter width, 2**CLOCK_COUNTER_BITS >= CLOCK_DIV
//
// Ports:
//   clk    in   system clock, rising edge
//   nreset in   asynchronous active-low reset
//   run    in   enables counting; counter cleared while low
//   tick   out  high during the final cycle of each bit period
// ============================================================================
module uart_baud_tick #(
    parameter int CLOCK_DIV          = 234,
    parameter int CLOCK_COUNTER_BITS = 8
) (
    input  logic clk,
    input  logic nreset,
    input  logic run,
    output logic tick
);

    localparam logic [CLOCK_COUNTER_BITS-1:0] LastCount =
        CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);

    logic [CLOCK_COUNTER_BITS-1:0] count_q;
    logic [CLOCK_COUNTER_BITS-1:0] count_d;

    // The tick is decoded from the registered count, so it is clean for the
    // whole cycle and lines up with the edge on which the bit should advance.
    assign tick = run && (count_q == LastCount);

    // Next count: park at zero when idle, wrap at the terminal count.
    always_comb begin
        count_d = count_q + CLOCK_COUNTER_BITS'(1);
        if (!run || tick) begin
            count_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : uart_baud_tick

// File: rtl/uart1_tx.sv
// ============================================================================
// uart1_tx
// ----------------------------------------------------------------------------
// Purpose : 8N1 UART transmitter with a fixed integer clock divider. Each
//           accepted 'send' request serialises one byte onto 'tx', LSB
//           first, framed by a start bit (0) and a stop bit (1). 'busy' is
//           high for the whole frame. Both outputs come straight from flops.
//
// Parameters:
//   CLOCK_DIV          - clk cycles per bit (default 27 MHz / 115200), >= 2
//   CLOCK_COUNTER_BITS - bit-period counter width, 2**bits >= CLOCK_DIV
//
// Ports:
//   clk    in   1  system clock, rising edge
//   nreset in   1  asynchronous active-low reset; abandons any frame
//   data   in   8  byte to send, sampled only on the accepting edge
//   send   in   1  level-sensitive request, ignored while busy
//   tx     out  1  serial line, idles high
//   busy   out  1  high while a frame is on the line
//
// Config  : UART1_TX_PARITY_EN - when defined, an even-parity bit
//           (XOR of the data byte) is sent between bit 7 and the stop bit,
//           giving an 11-bit frame. Undefined gives plain 8N1.
// ============================================================================
module uart1_tx
    import uart1_pkg::*;
#(
    parameter int CLOCK_DIV          = 234,
    parameter int CLOCK_COUNTER_BITS = 8
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       tx,
    output logic       busy
);

    uart_state_e state_q;
    uart_state_e state_d;
    logic [7:0]  shiftReg_q;
    logic [7:0]  shiftReg_d;
    logic [2:0]  bitIdx_q;
    logic [2:0]  bitIdx_d;
    logic        tx_q;
    logic        tx_d;
    logic        busy_q;
    logic        busy_d;
    logic        baudRun;
    logic        bitTick;

`ifdef UART1_TX_PARITY_EN
    logic        parity_q;
    logic        parity_d;
`endif

    // The timer only runs while a frame is in flight; in IDLE it sits at
    // zero so an accepted request always starts with a full start bit.
    assign baudRun = (state_q != IDLE);

    uart_baud_tick #(
        .CLOCK_DIV          (CLOCK_DIV),
        .CLOCK_COUNTER_BITS (CLOCK_COUNTER_BITS)
    ) uBaudTick (
        .clk    (clk),
        .nreset (nreset),
        .run    (baudRun),
        .tick   (bitTick)
    );

    // Frame sequencer. The line level and busy flag are decoded from the
    // *next* state and registered, so they change exactly on the edge where
    // the state changes and never glitch mid-bit. The shift register holds
    // the current data bit in bit 0 and shifts at the end of each data bit.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        bitIdx_d   = bitIdx_q;
`ifdef UART1_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (send) begin
                    state_d    = START;
                    shiftReg_d = data;
                    bitIdx_d   = '0;
`ifdef UART1_TX_PARITY_EN
                    parity_d   = ^data;
`endif
                end
            end
            START: begin
                if (bitTick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bitTick) begin
                    shiftReg_d = {1'b0, shiftReg_q[7:1]};
                    bitIdx_d   = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART1_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART1_TX_PARITY_EN
            PARITY: begin
                if (bitTick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bitTick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shiftReg_d[0];
`ifdef UART1_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State, datapath and output registers. Reset drops the line back to
    // idle immediately, abandoning any frame in progress.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitIdx_q   <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bitIdx_q   <= bitIdx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART1_TX_PARITY_EN
    // Parity is computed once from the accepted byte and held for the frame.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule : uart1_tx

// File: tb/tb_uart1_tx.sv
// ============================================================================
// tb_uart1_tx
// ----------------------------------------------------------------------------
// Self-checking bench for uart1_tx with a short divider (8 clocks per bit).
// The expected line level for any cycle of a frame is taken from a simple
// frame model: bit position = cycle / CLOCK_DIV, and each position maps to
// start, data[n], optional parity, or stop. Inputs are driven and outputs
// sampled on the falling clock edge.
// Config: UART1_TX_PARITY_EN selects the 11-bit frame in both DUT and model.
// ============================================================================
module tb_uart1_tx;

    localparam int DIV = 8;
    localparam int CB  = 4;
`ifdef UART1_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CYCLES = FB * DIV;

    logic       clk    = 1'b0;
    logic       nreset = 1'b1;
    logic       send   = 1'b0;
    logic [7:0] data   = 8'h00;
    logic       tx;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart1_tx #(
        .CLOCK_DIV          (DIV),
        .CLOCK_COUNTER_BITS (CB)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .data   (data),
        .send   (send),
        .tx     (tx),
        .busy   (busy)
    );

    // Line level at frame bit position pos for byte b.
    function automatic logic expectedBit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (FB == 11 && pos == 9) return ^b;
        return 1'b1;
    endfunction

    // Reset holds the line idle regardless of inputs, with or without clocks.
    task automatic test_reset();
        #1 nreset = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_async tx=%b busy=%b expected tx=1 busy=0", tx, busy);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            send = 1'($urandom);
            data = 8'($urandom);
            #1;
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_held cyc=%0d tx=%b busy=%b expected tx=1 busy=0", i, tx, busy);
            end
        end
        @(negedge clk);
        send   = 1'b0;
        nreset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_idle cyc=%0d tx=%b busy=%b expected tx=1 busy=0", i, tx, busy);
            end
        end
    endtask

    // Single frames from short send pulses; data is scrambled after accept.
    task automatic test_single_frame();
        logic [7:0] byteVal;
        int         pulse;
        for (int f = 0; f < 6; f++) begin
            byteVal = (f == 0) ? 8'h5A : (f == 1) ? 8'h01 : 8'($urandom);
            pulse   = (f == 0) ? 3 : int'($urandom_range(1, 5));
            @(negedge clk);
            data = byteVal;
            send = 1'b1;
            for (int i = 0; i < FRAME_CYCLES; i++) begin
                @(negedge clk);
                vectors++;
                if (tx !== expectedBit(byteVal, i / DIV) || busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL frame byte=%h cyc=%0d tx=%b busy=%b expected tx=%b busy=1",
                             byteVal, i, tx, busy, expectedBit(byteVal, i / DIV));
                end
                send = (i + 1 < pulse);
                data = 8'($urandom);
            end
            for (int i = 0; i < 2 * DIV; i++) begin
                @(negedge clk);
                vectors++;
                if (tx !== 1'b1 || busy !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL frame_after byte=%h cyc=%0d tx=%b busy=%b expected tx=1 busy=0",
                             byteVal, i, tx, busy);
                end
            end
        end
    endtask

    // Requests and data changes during a frame must not disturb it.
    task automatic test_ignored_requests();
        logic [7:0] byteVal;
        for (int f = 0; f < 2; f++) begin
            byteVal = (f == 0) ? 8'h5A : 8'hA5;
            @(negedge clk);
            data = byteVal;
            send = 1'b1;
            for (int i = 0; i < FRAME_CYCLES; i++) begin
                @(negedge clk);
                vectors++;
                if (tx !== expectedBit(byteVal, i / DIV) || busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL ignored byte=%h cyc=%0d tx=%b busy=%b expected tx=%b busy=1",
                             byteVal, i, tx, busy, expectedBit(byteVal, i / DIV));
                end
                send = (i + 1 < 3);
                if (f == 0 && (i == 20 || i == 50)) begin
                    data = 8'hA5;
                    send = 1'b1;
                end
            end
            for (int i = 0; i < 3 * DIV; i++) begin
                @(negedge clk);
                vectors++;
                if (tx !== 1'b1 || busy !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL ignored_after byte=%h cyc=%0d tx=%b busy=%b expected tx=1 busy=0",
                             byteVal, i, tx, busy);
                end
            end
        end
    endtask

    // Send held high: frames follow each other with one idle cycle between.
    task automatic test_back_to_back();
        logic [7:0] byteVal;
        byteVal = 8'h00;
        @(negedge clk);
        data = byteVal;
        send = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < FRAME_CYCLES; i++) begin
                @(negedge clk);
                vectors++;
                if (tx !== expectedBit(byteVal, i / DIV) || busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL b2b frame=%0d cyc=%0d tx=%b busy=%b expected tx=%b busy=1",
                             f, i, tx, busy, expectedBit(byteVal, i / DIV));
                end
            end
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL b2b_gap frame=%0d tx=%b busy=%b expected tx=1 busy=0", f, tx, busy);
            end
            byteVal = 8'($urandom);
            data    = byteVal;
            send    = (f < 3);
        end
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL b2b_end cyc=%0d tx=%b busy=%b expected tx=1 busy=0", i, tx, busy);
            end
        end
    endtask

    // Reset during data bit 3 idles the line at once; nothing resumes.
    task automatic test_mid_frame_reset();
        logic [7:0] byteVal;
        byteVal = 8'($urandom);
        @(negedge clk);
        data = byteVal;
        send = 1'b1;
        for (int i = 0; i < 4 * DIV + 3; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== expectedBit(byteVal, i / DIV) || busy !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL midrst_pre cyc=%0d tx=%b busy=%b expected tx=%b busy=1",
                         i, tx, busy, expectedBit(byteVal, i / DIV));
            end
            send = 1'b0;
        end
        #2 nreset = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_async tx=%b busy=%b expected tx=1 busy=0", tx, busy);
        end
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < FRAME_CYCLES + 10; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midrst_after cyc=%0d tx=%b busy=%b expected tx=1 busy=0", i, tx, busy);
            end
        end
    endtask

    initial begin
        $display("[TB] uart1_tx bench, %0d clocks per bit, %0d-bit frames", DIV, FB);
        test_reset();
        test_single_frame();
        test_ignored_requests();
        test_back_to_back();
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart1_tx
